// File: rtl/fifo_burst_drainer.sv
// fifo_burst_drainer: read-side consumer of the write-data FIFO. It pops
// words in order, packs up to BurstLen of them into one burst request with an
// auto-incrementing word address, and can flush a partial burst once the FIFO
// has run dry. Everything lives in the FIFO read-clock domain.
module fifo_burst_drainer #(
  parameter int                   DataWidth = 8,
  parameter int                   BurstLen  = 4,
  parameter int                   AddrWidth = 12,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_fifo_empty,
  output logic                          o_fifo_rd_en,
  input  logic [DataWidth-1:0]          i_fifo_rd_data,
  input  logic                          i_flush,
  output logic                          o_req_valid,
  input  logic                          i_req_ready,
  output logic [AddrWidth-1:0]          o_req_addr,
  output logic [DataWidth*BurstLen-1:0] o_req_data,
  output logic [$clog2(BurstLen):0]     o_req_words,
  output logic                          o_busy
);

  localparam int                  CntWidth = $clog2(BurstLen) + 1;
  localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(BurstLen);
  localparam logic [CntWidth-1:0] OneCnt   = CntWidth'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    REQ  = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [CntWidth-1:0]           issued_q, issued_d;
  logic [CntWidth-1:0]           captured_q, captured_d;
  logic                          rd_en_q;
  logic [AddrWidth-1:0]          addr_q, addr_d;
  logic [DataWidth*BurstLen-1:0] data_q, data_d;
  logic                          rd_en;
  logic                          flush_ok;

  // A flush may only close a burst once every popped word has landed in a slot.
  assign flush_ok = i_flush && i_fifo_empty && (captured_q == issued_q) &&
                    (captured_q != '0);

  // Next-state logic: pop scheduling, slot capture, flush and handshake.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    addr_d     = addr_q;
    data_d     = data_q;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!i_fifo_empty) begin
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        rd_en = !i_fifo_empty && (issued_q < FullCnt);
        if (rd_en) begin
          issued_d = issued_q + OneCnt;
        end else begin
          issued_d = issued_q;
        end
        // Read data trails the pop by one cycle; rd_en_q marks it valid.
        if (rd_en_q) begin
          data_d[captured_q*DataWidth +: DataWidth] = i_fifo_rd_data;
          captured_d = captured_q + OneCnt;
        end else begin
          captured_d = captured_q;
        end
        if (captured_d == FullCnt) begin
          state_d = REQ;
        end else if (flush_ok) begin
          state_d = REQ;
        end else begin
          state_d = FILL;
        end
      end
      REQ: begin
        if (i_req_ready) begin
          addr_d     = addr_q + AddrWidth'(captured_q);
          issued_d   = '0;
          captured_d = '0;
          data_d     = '0;
          state_d    = IDLE;
        end else begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered state; reset drops any words popped but not yet requested.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      captured_q <= '0;
      rd_en_q    <= 1'b0;
      addr_q     <= BaseAddr;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      rd_en_q    <= o_fifo_rd_en;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // The pop strobe is combinational so it can follow the empty flag directly.
  assign o_fifo_rd_en = rd_en && !i_rst;
  assign o_req_valid  = (state_q == REQ);
  assign o_busy       = (state_q != IDLE);
  assign o_req_addr   = addr_q;
  assign o_req_data   = data_q;
  assign o_req_words  = captured_q;

endmodule

// File: doc/fifo_burst_drainer.md
Name: fifo_burst_drainer

Overview:
Read-side consumer for the write-data FIFO. It pops words from the FIFO read port and packs BurstLen words into one write-burst request for the SDRAM command sequencer, using a valid/ready handshake. It generates an auto-incrementing burst address. It also supports flushing a partial burst when the FIFO runs dry. It runs entirely in the FIFO read-clock domain.

Parameters:
DataWidth, 8, width of one FIFO word
BurstLen, 4, words per full burst; power of two, at least 2
AddrWidth, 12, width of the word address
BaseAddr, 0, address of the first burst after reset

Ports:
i_clk  in  1  clock; the FIFO read clock
i_rst  in  1  reset; synchronous, active-high
i_fifo_empty  in  1  FIFO empty flag
o_fifo_rd_en  out  1  FIFO pop strobe
i_fifo_rd_data  in  DataWidth  FIFO read data; valid the cycle after o_fifo_rd_en
i_flush  in  1  level; emit a partial burst once the FIFO is empty
o_req_valid  out  1  burst request valid
i_req_ready  in  1  sequencer accepts the request
o_req_addr  out  AddrWidth  word address of the burst's first word
o_req_data  out  DataWidth*BurstLen  packed words; word 0 sits in the LSBs
o_req_words  out  $clog2(BurstLen)+1  number of valid words, 1..BurstLen
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (i_rst high at a clock edge):
  - state goes to IDLE; the issued and captured counters clear.
  - o_fifo_rd_en=0, o_req_valid=0, o_req_data=0, o_req_words=0, o_busy=0.
  - the address register loads BaseAddr.
  - Words already popped from the FIFO but not yet requested are discarded. This is the required behaviour for reset mid-burst, not a bug.
  - During the reset cycle, o_fifo_rd_en is 0 regardless of the registered state.
- State machine with states IDLE, FILL, REQ:
  - IDLE: if i_fifo_empty=0, go to FILL next cycle. Otherwise stay.
  - FILL:
    - o_fifo_rd_en = !i_fifo_empty && (issued < BurstLen). It is combinational and never asserted while i_fifo_empty=1.
    - issued increments on each rd_en.
    - A registered copy of rd_en marks the cycle in which i_fifo_rd_data is captured into slot[captured]; captured then increments.
    - Go to REQ when captured reaches BurstLen.
    - Flush: go to REQ when all of the following hold in the same cycle: i_flush=1, i_fifo_empty=1, captured==issued, captured>0. o_req_words then equals captured. Unused slots hold 0.
    - A flush with captured==0 is ignored, and the FSM stays in FILL waiting for data.
  - REQ:
    - o_req_valid=1. No FIFO reads are issued.
    - o_req_addr, o_req_data and o_req_words stay stable while i_req_ready=0.
    - On a cycle with valid && ready: address += o_req_words (modulo 2^AddrWidth, wrapping silently); counters and slots clear; next state is IDLE.
    - o_req_valid is 0 in the cycle after the handshake.
- Latency, from IDLE with at least BurstLen words in the FIFO and i_req_ready=1:
  - cycle 0: i_fifo_empty low is observed.
  - cycles 1-4: o_fifo_rd_en high.
  - cycles 2-5: data captured.
  - cycle 6: o_req_valid high; the handshake completes in cycle 6.
- FIFO emptying mid-FILL: rd_en drops while empty and resumes when empty deasserts. Captured words are retained.
- Words are placed in pop order. The slot index equals pop order within the burst.
- The output registers change only on reset, slot capture in FILL, or a handshake.

Test Plan:
- Reset: assert i_rst for 2 cycles while FIFO is non-empty -> o_fifo_rd_en=0, o_req_valid=0, o_busy=0; after release, the first request has o_req_addr=0x000.
- Full burst: FIFO preloaded with 0xA1,0xB2,0xC3,0xD4, i_req_ready=1 -> exactly 4 rd_en pulses; o_req_valid rises 6 cycles after empty falls; o_req_data=0xD4C3B2A1, o_req_words=4, o_req_addr=0x000; the next burst's addr is 0x004.
- Backpressure: hold i_req_ready=0 for 5 cycles -> o_req_valid stays 1 with stable data/addr, no rd_en in that window; ready=1 -> valid drops the next cycle.
- Partial flush: 3 words (0x11,0x22,0x33) then FIFO empty, i_flush=1 -> o_req_words=3, o_req_data=0x00332211; the next address advances by 3.
- Wrap: BaseAddr=0xFFC, two full bursts -> addresses 0xFFC then 0x000.
- Reset mid-FILL: assert i_rst after 2 captures -> state IDLE, the next burst contains only words popped after reset, addr=BaseAddr.
